hast_axi_lite_pattern_master: RTL

AXI4-Lite master traffic stage that sits directly upstream of the Hast_IP S00_AXI register slave. A rising edge on INIT_AXI_TXN starts a fixed-pattern run:
- NUM_WORDS single-beat writes to consecutive word addresses.
- The same number of read-backs, each compared against the expected pattern.

It reports completion on TXN_DONE and any response or data mismatch on ERROR. The block is the M00_AXI-side self-test engine in the block design.

---
 rtl/hast_axi_lite_pattern_master_if.sv | 53 +++++
 rtl/hast_axi_lite_pattern_master.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hast_axi_lite_pattern_master_if.sv
// AXI4-Lite bus bundle between the pattern master and the register slave.
// The master modport drives the request channels and the response readies;
// the slave modport is the mirror image.
interface hast_axi_lite_pattern_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/hast_axi_lite_pattern_master.sv
// AXI4-Lite self-test master: on a rising edge of INIT_AXI_TXN it writes
// NUM_WORDS pattern words (SEED + i) to consecutive word addresses, reads them
// back one at a time and flags any bad response or data mismatch on ERROR.
module hast_axi_lite_pattern_master #(
    parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH   = 32,
    parameter int          C_M_AXI_DATA_WIDTH   = 32,
    parameter int          NUM_WORDS            = 4,
    parameter logic [31:0] SEED                 = 32'h0101_FFFF
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic INIT_AXI_TXN,
    output logic TXN_DONE,
    output logic ERROR,
    hast_axi_lite_pattern_master_if.master m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int IW = $clog2(NUM_WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t          state_reg, state_next;
    logic            init_q;
    logic            awvalid_reg, wvalid_reg, bready_reg;
    logic            arvalid_reg, rready_reg;
    logic [AW-1:0]   awaddr_reg, araddr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [IW-1:0]   widx_reg, ridx_reg;
    logic            txn_done_reg, error_reg;

    logic start, aw_hs, w_hs, b_hs, ar_hs, r_hs, b_last, r_last;

    // Word address and pattern value for a given index, both modulo 2^32.
    function automatic logic [AW-1:0] word_addr(input logic [IW-1:0] idx);
        return AW'(C_M_TARGET_BASE_ADDR + (32'(idx) << 2));
    endfunction

    function automatic logic [DW-1:0] word_data(input logic [IW-1:0] idx);
        return DW'(SEED + 32'(idx));
    endfunction

    assign start  = INIT_AXI_TXN & ~init_q & ((state_reg == IDLE) | (state_reg == DONE));
    assign aw_hs  = awvalid_reg & m_axi.M_AXI_AWREADY;
    assign w_hs   = wvalid_reg  & m_axi.M_AXI_WREADY;
    assign b_hs   = bready_reg  & m_axi.M_AXI_BVALID;
    assign ar_hs  = arvalid_reg & m_axi.M_AXI_ARREADY;
    assign r_hs   = rready_reg  & m_axi.M_AXI_RVALID;
    assign b_last = (state_reg == WRITE) & b_hs & (widx_reg == LAST_IDX);
    assign r_last = (state_reg == READ)  & r_hs & (ridx_reg == LAST_IDX);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: runs go IDLE/DONE -> WRITE -> READ -> DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start)  state_next = WRITE;
            WRITE:      if (b_last) state_next = READ;
            READ:       if (r_last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Channel handshakes, index counters and result flags. A word is always in
    // flight while in WRITE/READ: the next one is issued on the edge that
    // completes the previous response, so only one transaction is outstanding.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q       <= 1'b0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            arvalid_reg  <= 1'b0;
            rready_reg   <= 1'b0;
            awaddr_reg   <= AW'(C_M_TARGET_BASE_ADDR);
            araddr_reg   <= AW'(C_M_TARGET_BASE_ADDR);
            wdata_reg    <= DW'(SEED);
            widx_reg     <= '0;
            ridx_reg     <= '0;
            txn_done_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            init_q     <= INIT_AXI_TXN;
            bready_reg <= 1'b0;
            rready_reg <= 1'b0;
            if (start) begin
                awvalid_reg  <= 1'b1;
                wvalid_reg   <= 1'b1;
                awaddr_reg   <= word_addr('0);
                wdata_reg    <= word_data('0);
                widx_reg     <= '0;
                ridx_reg     <= '0;
                txn_done_reg <= 1'b0;
                error_reg    <= 1'b0;
            end else if (state_reg == WRITE) begin
                if (aw_hs) awvalid_reg <= 1'b0;
                if (w_hs)  wvalid_reg  <= 1'b0;
                // Response wait begins only once both AW and W have been accepted.
                bready_reg <= ~awvalid_reg & ~wvalid_reg & m_axi.M_AXI_BVALID & ~bready_reg;
                if (b_hs) begin
                    if (m_axi.M_AXI_BRESP[1]) error_reg <= 1'b1;
                    if (widx_reg == LAST_IDX) begin
                        arvalid_reg <= 1'b1;
                        araddr_reg  <= word_addr('0);
                        ridx_reg    <= '0;
                    end else begin
                        widx_reg    <= widx_reg + 1'b1;
                        awaddr_reg  <= word_addr(widx_reg + 1'b1);
                        wdata_reg   <= word_data(widx_reg + 1'b1);
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                    end
                end
            end else if (state_reg == READ) begin
                if (ar_hs) arvalid_reg <= 1'b0;
                rready_reg <= ~arvalid_reg & m_axi.M_AXI_RVALID & ~rready_reg;
                if (r_hs) begin
                    if (m_axi.M_AXI_RRESP[1] || (m_axi.M_AXI_RDATA != word_data(ridx_reg)))
                        error_reg <= 1'b1;
                    if (ridx_reg == LAST_IDX) begin
                        txn_done_reg <= 1'b1;
                    end else begin
                        ridx_reg    <= ridx_reg + 1'b1;
                        araddr_reg  <= word_addr(ridx_reg + 1'b1);
                        arvalid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    // Output decode: bus outputs come straight from registers; PROT/STRB fixed.
    always_comb begin
        m_axi.M_AXI_AWADDR  = awaddr_reg;
        m_axi.M_AXI_AWPROT  = 3'b000;
        m_axi.M_AXI_AWVALID = awvalid_reg;
        m_axi.M_AXI_WDATA   = wdata_reg;
        m_axi.M_AXI_WSTRB   = '1;
        m_axi.M_AXI_WVALID  = wvalid_reg;
        m_axi.M_AXI_BREADY  = bready_reg;
        m_axi.M_AXI_ARADDR  = araddr_reg;
        m_axi.M_AXI_ARPROT  = 3'b000;
        m_axi.M_AXI_ARVALID = arvalid_reg;
        m_axi.M_AXI_RREADY  = rready_reg;
        TXN_DONE            = txn_done_reg;
        ERROR               = error_reg;
    end
endmodule
